// File: rtl/sni_tbl_pkg.sv
// Shared types and constants for the SNI two-byte pre-filter table writer.
// Pure definitions: no latency, no flow control.
package sni_tbl_pkg;

  localparam int         TBL_DEPTH   = 256;
  localparam int         TBL_AW      = 8;
  localparam logic [7:0] EMPTY_ENTRY = 8'h00;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    DRAIN = 2'd2
  } tbl_state_e;

  typedef struct packed {
    logic              en;
    logic [TBL_AW-1:0] addr;
    logic [7:0]        data;
  } tbl_wr_t;

  function automatic logic [7:0] to_lower(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h5A)) ? (b + 8'h20) : b;
  endfunction

endpackage

// File: rtl/sni_tbl_sweep_ctr.sv
// Sweep address counter: steps once per enabled cycle, restart wins over step.
// done is combinational on the cycle that presents the last address; no backpressure.
module sni_tbl_sweep_ctr
  import sni_tbl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              en,
  input  logic              restart,
  output logic [TBL_AW-1:0] cnt,
  output logic              done
);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = en && !restart && (cnt == '1);

endmodule

// File: rtl/sni_bytes_table_writer.sv
// Writes table[first_byte] = second_byte for each SNI pattern; zero-sweeps on reset/clear.
// Latency: table write registered, 1 cycle after accept. Backpressure: ready low while sweeping or on clear.
// Optional build macro SNI_TBL_CASE_FOLD_EN folds ASCII upper case to lower case before lookup and write.
module sni_bytes_table_writer
  import sni_tbl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_pat_data,
  input  logic [3:0]        i_pat_bytes,
  input  logic              i_pat_last,
  input  logic              i_pat_valid,
  output logic              o_pat_ready,
  output logic              o_tbl_wr_en,
  output logic [7:0]        o_tbl_wr_addr,
  output logic [7:0]        o_tbl_wr_data,
  output logic              o_table_ready,
  output logic [8:0]        o_entry_cnt,
  output logic [CNT_W-1:0]  o_collision_cnt,
  output logic [CNT_W-1:0]  o_reject_cnt
);

  tbl_state_e           state_q, state_d;
  logic                 drain_pend_q;
  logic [TBL_DEPTH-1:0] occ_q;
  logic [7:0]           shadow_q [TBL_DEPTH];
  tbl_wr_t              wr_q;
  logic                 table_ready_q;
  logic [8:0]           entry_cnt_q;
  logic [CNT_W-1:0]     coll_cnt_q, rej_cnt_q;

  logic [TBL_AW-1:0]    sweep_cnt;
  logic                 sweep_done;
  logic                 accept, first_acc, is_short, hit, dup;
  logic                 new_ent, coll, rej;
  logic [7:0]           b0, b1;
  logic                 unused_hi_bytes;

`ifdef SNI_TBL_CASE_FOLD_EN
  assign b0 = to_lower(i_pat_data[7:0]);
  assign b1 = to_lower(i_pat_data[15:8]);
`else
  assign b0 = i_pat_data[7:0];
  assign b1 = i_pat_data[15:8];
`endif
  assign unused_hi_bytes = ^i_pat_data[DATA_W-1:16];

  sni_tbl_sweep_ctr u_sweep (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .en      (state_q == CLEAR),
    .restart (i_clear),
    .cnt     (sweep_cnt),
    .done    (sweep_done)
  );

  // A beat offered alongside i_clear is refused so it is not lost during the sweep.
  assign o_pat_ready = (state_q != CLEAR) && !i_clear;
  assign accept      = i_pat_valid && o_pat_ready;

  // Only the first beat of a pattern carries the two key bytes.
  assign first_acc = accept && (state_q == IDLE);
  assign is_short  = (i_pat_bytes < 4'd2) || (b1 == EMPTY_ENTRY);
  assign hit       = occ_q[b0];
  assign dup       = hit && (shadow_q[b0] == b1);
  assign new_ent   = first_acc && !is_short && !hit;
  assign coll      = first_acc && !is_short && hit && !dup;
  assign rej       = first_acc && is_short;

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        CLEAR:   if (sweep_done) state_d = drain_pend_q ? DRAIN : IDLE;
        IDLE:    if (accept && !i_pat_last) state_d = DRAIN;
        DRAIN:   if (accept && i_pat_last) state_d = IDLE;
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Remember an interrupted pattern so its tail is swallowed once the sweep ends.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      drain_pend_q <= 1'b0;
    end else if (i_clear) begin
      drain_pend_q <= drain_pend_q || (state_q == DRAIN) ||
                      ((state_q == IDLE) && i_pat_valid && !i_pat_last);
    end else if (sweep_done) begin
      drain_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_q          <= '0;
      table_ready_q <= 1'b0;
      entry_cnt_q   <= '0;
      occ_q         <= '0;
      coll_cnt_q    <= '0;
      rej_cnt_q     <= '0;
    end else begin
      table_ready_q <= (state_q != CLEAR) && !i_clear;

      wr_q <= '0;
      if (state_q == CLEAR) begin
        wr_q <= '{en: 1'b1, addr: sweep_cnt, data: EMPTY_ENTRY};
      end else if (new_ent) begin
        wr_q <= '{en: 1'b1, addr: b0, data: b1};
      end

      if (i_clear) begin
        occ_q       <= '0;
        entry_cnt_q <= '0;
      end else if (new_ent) begin
        occ_q[b0]   <= 1'b1;
        entry_cnt_q <= entry_cnt_q + 9'd1;
      end

      if (coll && (coll_cnt_q != '1)) coll_cnt_q <= coll_cnt_q + 1'b1;
      if (rej && (rej_cnt_q != '1))   rej_cnt_q  <= rej_cnt_q + 1'b1;
    end
  end

  // Shadow copy of written second bytes; only read when the occupancy bit is set.
  always_ff @(posedge i_clk) begin
    if (new_ent) shadow_q[b0] <= b1;
  end

  assign o_tbl_wr_en     = wr_q.en;
  assign o_tbl_wr_addr   = wr_q.addr;
  assign o_tbl_wr_data   = wr_q.data;
  assign o_table_ready   = table_ready_q;
  assign o_entry_cnt     = entry_cnt_q;
  assign o_collision_cnt = coll_cnt_q;
  assign o_reject_cnt    = rej_cnt_q;

endmodule

// File: tb/tb_sni_bytes_table_writer.sv
// Bench for sni_bytes_table_writer: directed and random patterns against a table-level model,
// with expected RAM writes scoreboarded by address, data and cycle of appearance.
module tb_sni_bytes_table_writer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_clear = 1'b0;
  logic [63:0] i_pat_data = '0;
  logic [3:0]  i_pat_bytes = '0;
  logic        i_pat_last = 1'b0;
  logic        i_pat_valid = 1'b0;
  logic        o_pat_ready, o_tbl_wr_en, o_table_ready;
  logic [7:0]  o_tbl_wr_addr, o_tbl_wr_data;
  logic [8:0]  o_entry_cnt;
  logic [7:0]  o_collision_cnt, o_reject_cnt;

  sni_bytes_table_writer #(.DATA_W(64), .CNT_W(8)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_clear         (i_clear),
    .i_pat_data      (i_pat_data),
    .i_pat_bytes     (i_pat_bytes),
    .i_pat_last      (i_pat_last),
    .i_pat_valid     (i_pat_valid),
    .o_pat_ready     (o_pat_ready),
    .o_tbl_wr_en     (o_tbl_wr_en),
    .o_tbl_wr_addr   (o_tbl_wr_addr),
    .o_tbl_wr_data   (o_tbl_wr_data),
    .o_table_ready   (o_table_ready),
    .o_entry_cnt     (o_entry_cnt),
    .o_collision_cnt (o_collision_cnt),
    .o_reject_cnt    (o_reject_cnt)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t expq[$];

  int checks = 0;
  int errors = 0;

  // Table-level reference model.
  bit   m_occ [256];
  int   m_val [256];
  int   m_entries = 0;
  int   m_coll = 0;
  int   m_rej = 0;
  bit   m_in_pat = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int fold(input int b);
`ifdef SNI_TBL_CASE_FOLD_EN
    return (b >= 'h41 && b <= 'h5A) ? b + 'h20 : b;
`else
    return b;
`endif
  endfunction

  task automatic push_sweep(input int first);
    for (int i = 0; i < 256; i++) begin
      exp_t e;
      e.addr = 8'(i);
      e.data = 8'h00;
      e.cyc  = first + 1 + i;
      expq.push_back(e);
    end
  endtask

  task automatic model_accept(input logic [63:0] d, input int n, input bit last, input int at);
    int b0, b1;
    if (!m_in_pat) begin
      b0 = fold(int'(d[7:0]));
      b1 = fold(int'(d[15:8]));
      if (n < 2 || b1 == 0) begin
        if (m_rej < 255) m_rej++;
      end else if (m_occ[b0]) begin
        if (m_val[b0] != b1 && m_coll < 255) m_coll++;
      end else begin
        exp_t e;
        m_occ[b0] = 1'b1;
        m_val[b0] = b1;
        m_entries++;
        e.addr = 8'(b0);
        e.data = 8'(b1);
        e.cyc  = at;
        expq.push_back(e);
      end
    end
    m_in_pat = !last;
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge i_clk) begin
    if (i_rst && o_tbl_wr_en) begin
      exp_t e;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr %0h data %0h cyc %0d", o_tbl_wr_addr, o_tbl_wr_data, cyc);
      end else begin
        e = expq.pop_front();
        if (o_tbl_wr_addr !== e.addr || o_tbl_wr_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                   o_tbl_wr_addr, o_tbl_wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input int n, input bit last);
    int t = 0;
    i_pat_data  = d;
    i_pat_bytes = 4'(n);
    i_pat_last  = last;
    i_pat_valid = 1'b1;
    @(negedge i_clk);
    while (!o_pat_ready && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_pat_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got ready %0b expected 1", o_pat_ready);
    end else begin
      model_accept(d, n, last, cyc + 1);
    end
    @(posedge i_clk);
    #1;
    i_pat_valid = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    m_occ = '{default: 1'b0};
    m_entries = 0;
    push_sweep(cyc + 1);
    @(posedge i_clk);
    #1;
    i_clear = 1'b0;
  endtask

  task automatic wait_table_ready();
    int t = 0;
    while (!o_table_ready && t < 1000) begin
      @(negedge i_clk);
      t++;
    end
    chk("table_ready_wait", o_table_ready, 1);
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] r;
    case ($urandom_range(0, 7))
      0: r = 8'h61;
      1: r = 8'h41;
      2: r = 8'h77;
      3: r = 8'h57;
      4: r = 8'h74;
      5: r = 8'h00;
      6: r = 8'h5A;
      default: r = 8'($urandom_range(0, 255));
    endcase
    return r;
  endfunction

  initial begin
    int bad;
    int nb;
    logic [63:0] d;

    repeat (3) @(negedge i_clk);
    chk("rst_wr_en", o_tbl_wr_en, 0);
    chk("rst_table_ready", o_table_ready, 0);
    chk("rst_entry_cnt", o_entry_cnt, 0);
    chk("rst_counters", {o_collision_cnt, o_reject_cnt}, 0);
    chk("rst_pat_ready", o_pat_ready, 0);

    i_rst = 1'b1;
    push_sweep(cyc);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (o_pat_ready !== 1'b0 || o_table_ready !== 1'b0) bad++;
      @(negedge i_clk);
    end
    chk("sweep_ready_low", bad, 0);
    chk("table_ready_c256", o_table_ready, 0);
    chk("pat_ready_idle", o_pat_ready, 1);
    @(negedge i_clk);
    chk("table_ready_c257", o_table_ready, 1);
    @(posedge i_clk);
    #1;

    send_beat(64'h2E777777, 4, 1'b1);
    chk("www_wr_en", o_tbl_wr_en, 1);
    chk("www_wr_addr", o_tbl_wr_addr, 8'h77);
    chk("www_entry_cnt", o_entry_cnt, 1);

    send_beat(64'h7777, 2, 1'b1);
    send_beat(64'h6177, 2, 1'b1);
    chk("wa_collision", o_collision_cnt, 1);
    send_beat(64'h7777, 2, 1'b1);
    chk("ww_dup_collision", o_collision_cnt, 1);
    chk("ww_dup_entry_cnt", o_entry_cnt, 1);

    send_beat(64'h632E6B6F746B6974, 8, 1'b0);
    send_beat(64'h6F, 1, 1'b0);
    send_beat(64'h6D, 1, 1'b1);
    send_beat(64'h6261, 2, 1'b1);
    chk("tiktok_ab_entry_cnt", o_entry_cnt, 3);
    chk("tail_not_rejected", o_reject_cnt, 0);

    send_beat(64'h78, 1, 1'b1);
    chk("short_reject", o_reject_cnt, 1);
    send_beat(64'h0071, 2, 1'b1);
    chk("zero_b1_reject", o_reject_cnt, 2);

    send_beat(64'h2E2E797A, 4, 1'b0);
    chk("zy_entry_cnt", o_entry_cnt, 4);
    do_clear();
    chk("clr_table_ready", o_table_ready, 0);
    chk("clr_entry_cnt", o_entry_cnt, 0);
    chk("clr_pat_ready", o_pat_ready, 0);
    chk("clr_counters_kept", {o_collision_cnt, o_reject_cnt}, {8'd1, 8'd2});
    send_beat(64'h7878, 2, 1'b1);
    chk("tail_discarded_cnt", o_entry_cnt, 0);
    send_beat(64'h5757, 2, 1'b1);
`ifdef SNI_TBL_CASE_FOLD_EN
    chk("WW_wr_addr", o_tbl_wr_addr, 8'h77);
`else
    chk("WW_wr_addr", o_tbl_wr_addr, 8'h57);
`endif
    chk("WW_entry_cnt", o_entry_cnt, 1);
    wait_table_ready();

    for (int p = 0; p < 150; p++) begin
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        d = {$urandom, $urandom};
        d[7:0]  = pick();
        d[15:8] = pick();
        send_beat(d, $urandom_range(1, 8), (j == nb - 1));
        if (j == 0 && nb > 1 && $urandom_range(0, 24) == 0) do_clear();
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk);
        #1;
      end
    end

    wait_table_ready();
    repeat (3) @(negedge i_clk);
    chk("queue_drained", expq.size(), 0);
    chk("final_entry_cnt", o_entry_cnt, m_entries);
    chk("final_collision_cnt", o_collision_cnt, m_coll);
    chk("final_reject_cnt", o_reject_cnt, m_rej);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
